// File: rtl/store_queue_circ.sv
// Circular store queue: holds speculative and committed stores, drains committed
// stores to L1D one at a time, and forwards store bytes to loads from the youngest match.
module store_queue_circ #(
   parameter int PHYS     = 32,
   parameter int DEPTH    = 16,
   parameter int ROB_W    = 5,
   parameter int COMMIT_W = 2
) (
   input  logic                           cpu_clk_i,
   input  logic                           cpu_rst_i,
   input  logic                           flush_i,
   input  logic                           enq_valid_i,
   output logic                           enq_ready_o,
   input  logic [PHYS-3:0]                enq_address_i,
   input  logic [31:0]                    enq_data_i,
   input  logic [3:0]                     enq_bm_i,
   input  logic                           enq_io_i,
   input  logic [ROB_W-1:0]               enq_rob_i,
   output logic [ROB_W-1:0]               complete_o,
   output logic                           complete_vld_o,
   input  logic [$clog2(COMMIT_W+1)-1:0]  commit_cnt_i,
   input  logic [PHYS-3:0]                fwd_address_i,
   input  logic [3:0]                     fwd_bm_i,
   output logic [31:0]                    fwd_data_o,
   output logic [3:0]                     fwd_bm_o,
   output logic                           fwd_hit_o,
   output logic                           fwd_resolvable_o,
   output logic [PHYS-3:0]                store_address_o,
   output logic [31:0]                    store_data_o,
   output logic [3:0]                     store_bm_o,
   output logic                           store_io_o,
   output logic                           store_valid_o,
   input  logic                           cache_done_i,
   output logic                           no_nonspec_o,
   output logic [$clog2(DEPTH+1)-1:0]     count_o
);

   localparam int AW = PHYS - 2;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   // Entry payload; read combinationally by the forwarding network, so kept in flops.
   logic [AW-1:0] addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [3:0]    bm_mem   [DEPTH];
   logic          io_mem   [DEPTH];

   logic [PW-1:0]    head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
   logic [CW-1:0]    ncount_q, ncount_d, scount_q, scount_d;
   logic [CW-1:0]    count_w, commit_n;
   logic             accept, drain_done;

   logic             store_valid_q, store_valid_d;
   logic [AW-1:0]    store_address_q, store_address_d;
   logic [31:0]      store_data_q, store_data_d;
   logic [3:0]       store_bm_q, store_bm_d;
   logic             store_io_q, store_io_d;
   logic             complete_vld_q;
   logic [ROB_W-1:0] complete_q;
   logic [PW-1:0]    head_next;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
      logic [CW:0] s;
      s = (CW+1)'(p) + (CW+1)'(n);
      if (s >= (CW+1)'(DEPTH))
         s = s - (CW+1)'(DEPTH);
      return s[PW-1:0];
   endfunction

   assign count_w     = ncount_q + scount_q;
   assign count_o     = count_w;
   assign enq_ready_o = (count_w != CW'(DEPTH));
   assign accept      = enq_valid_i & enq_ready_o & ~flush_i;
   assign drain_done  = store_valid_q & cache_done_i;
   assign no_nonspec_o = (ncount_q == '0);
   assign head_next   = wrap_add(head_q, CW'(1));

   // Excess commit requests beyond the speculative population are dropped.
   always_comb begin
      commit_n = CW'(commit_cnt_i);
      if (int'(commit_cnt_i) > int'(scount_q))
         commit_n = scount_q;
   end

   always_comb begin
      ncount_d = ncount_q - CW'(drain_done) + commit_n;
      scount_d = scount_q - commit_n;
      if (flush_i)
         scount_d = '0;
      scount_d = scount_d + CW'(accept);
      head_d = drain_done ? head_next : head_q;
      cmt_d  = wrap_add(cmt_q, commit_n);
      tail_d = tail_q;
      if (flush_i)
         tail_d = cmt_d;
      else if (accept)
         tail_d = wrap_add(tail_q, CW'(1));
   end

   always_comb begin
      store_valid_d   = store_valid_q;
      store_address_d = store_address_q;
      store_data_d    = store_data_q;
      store_bm_d      = store_bm_q;
      store_io_d      = store_io_q;
      if (!store_valid_q) begin
         if (ncount_q != '0) begin
            store_valid_d   = 1'b1;
            store_address_d = addr_mem[head_q];
            store_data_d    = data_mem[head_q];
            store_bm_d      = bm_mem[head_q];
            store_io_d      = io_mem[head_q];
         end
      end else if (cache_done_i) begin
         // Next committed entry goes out on the very next cycle, no bubble.
         if (ncount_q > CW'(1)) begin
            store_address_d = addr_mem[head_next];
            store_data_d    = data_mem[head_next];
            store_bm_d      = bm_mem[head_next];
            store_io_d      = io_mem[head_next];
         end else begin
            store_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
      if (cpu_rst_i) begin
         head_q          <= '0;
         cmt_q           <= '0;
         tail_q          <= '0;
         ncount_q        <= '0;
         scount_q        <= '0;
         store_valid_q   <= 1'b0;
         store_address_q <= '0;
         store_data_q    <= '0;
         store_bm_q      <= '0;
         store_io_q      <= 1'b0;
         complete_vld_q  <= 1'b0;
         complete_q      <= '0;
      end else begin
         head_q          <= head_d;
         cmt_q           <= cmt_d;
         tail_q          <= tail_d;
         ncount_q        <= ncount_d;
         scount_q        <= scount_d;
         store_valid_q   <= store_valid_d;
         store_address_q <= store_address_d;
         store_data_q    <= store_data_d;
         store_bm_q      <= store_bm_d;
         store_io_q      <= store_io_d;
         complete_vld_q  <= accept;
         if (accept)
            complete_q <= enq_rob_i;
      end
   end

   always_ff @(posedge cpu_clk_i) begin
      if (accept) begin
         addr_mem[tail_q] <= enq_address_i;
         data_mem[tail_q] <= enq_data_i;
         bm_mem[tail_q]   <= enq_bm_i;
         io_mem[tail_q]   <= enq_io_i;
      end
   end

   // Walk oldest to youngest from head so later (younger) matches override per byte.
   always_comb begin : fwd_logic
      logic [PW-1:0] idx;
      logic [3:0]    byte_io;
      idx        = '0;
      byte_io    = '0;
      fwd_data_o = '0;
      fwd_bm_o   = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = wrap_add(head_q, CW'(k));
         if ((CW'(k) < count_w) && (addr_mem[idx] == fwd_address_i)) begin
            for (int b = 0; b < 4; b++) begin
               if (bm_mem[idx][b] && fwd_bm_i[b]) begin
                  fwd_data_o[8*b +: 8] = data_mem[idx][8*b +: 8];
                  fwd_bm_o[b]          = 1'b1;
                  byte_io[b]           = io_mem[idx];
               end
            end
         end
      end
      fwd_hit_o        = |fwd_bm_o;
      fwd_resolvable_o = fwd_hit_o & (fwd_bm_o == fwd_bm_i) & ~(|byte_io);
   end

   assign store_valid_o   = store_valid_q;
   assign store_address_o = store_address_q;
   assign store_data_o    = store_data_q;
   assign store_bm_o      = store_bm_q;
   assign store_io_o      = store_io_q;
   assign complete_vld_o  = complete_vld_q;
   assign complete_o      = complete_q;

endmodule

// File: tb/tb_store_queue_circ.sv
// Directed bench for store_queue_circ: enqueue/complete, commit/drain, forwarding,
// flush, wrap-around age ordering and asynchronous reset.
module tb_store_queue_circ;

   logic        cpu_clk_i = 1'b0;
   logic        cpu_rst_i;
   logic        flush_i, enq_valid_i, enq_ready_o, enq_io_i;
   logic [29:0] enq_address_i, fwd_address_i, store_address_o;
   logic [31:0] enq_data_i, fwd_data_o, store_data_o;
   logic [3:0]  enq_bm_i, fwd_bm_i, fwd_bm_o, store_bm_o;
   logic [4:0]  enq_rob_i, complete_o, count_o;
   logic        complete_vld_o, fwd_hit_o, fwd_resolvable_o;
   logic [1:0]  commit_cnt_i;
   logic        store_io_o, store_valid_o, cache_done_i, no_nonspec_o;

   int n_checks = 0;
   int n_fail   = 0;

   store_queue_circ dut (
      .cpu_clk_i(cpu_clk_i), .cpu_rst_i(cpu_rst_i), .flush_i(flush_i),
      .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
      .enq_address_i(enq_address_i), .enq_data_i(enq_data_i), .enq_bm_i(enq_bm_i),
      .enq_io_i(enq_io_i), .enq_rob_i(enq_rob_i),
      .complete_o(complete_o), .complete_vld_o(complete_vld_o),
      .commit_cnt_i(commit_cnt_i),
      .fwd_address_i(fwd_address_i), .fwd_bm_i(fwd_bm_i), .fwd_data_o(fwd_data_o),
      .fwd_bm_o(fwd_bm_o), .fwd_hit_o(fwd_hit_o), .fwd_resolvable_o(fwd_resolvable_o),
      .store_address_o(store_address_o), .store_data_o(store_data_o),
      .store_bm_o(store_bm_o), .store_io_o(store_io_o), .store_valid_o(store_valid_o),
      .cache_done_i(cache_done_i), .no_nonspec_o(no_nonspec_o), .count_o(count_o)
   );

   always #5 cpu_clk_i = ~cpu_clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge cpu_clk_i);
      #1;
   endtask

   task automatic enq_set(input logic [29:0] a, input logic [31:0] d, input logic [3:0] bm,
                          input logic io, input logic [4:0] rob);
      enq_valid_i   = 1'b1;
      enq_address_i = a;
      enq_data_i    = d;
      enq_bm_i      = bm;
      enq_io_i      = io;
      enq_rob_i     = rob;
   endtask

   task automatic fwd_probe(input logic [29:0] a, input logic [3:0] bm);
      fwd_address_i = a;
      fwd_bm_i      = bm;
      #1;
   endtask

   initial begin
      cpu_rst_i = 1'b1; flush_i = 0; enq_valid_i = 0; enq_address_i = '0; enq_data_i = '0;
      enq_bm_i = '0; enq_io_i = 0; enq_rob_i = '0; commit_cnt_i = '0;
      fwd_address_i = '0; fwd_bm_i = '0; cache_done_i = 0;
      tick(); tick();
      cpu_rst_i = 1'b0;
      #1;
      check("rst_store_valid", 32'(store_valid_o), 0);
      check("rst_complete_vld", 32'(complete_vld_o), 0);
      check("rst_complete", 32'(complete_o), 0);
      check("rst_enq_ready", 32'(enq_ready_o), 1);
      check("rst_no_nonspec", 32'(no_nonspec_o), 1);
      check("rst_count", 32'(count_o), 0);

      // Three stores, completions on consecutive cycles
      for (int i = 0; i < 3; i++) begin
         enq_set(30'h10 + 30'(i), 32'hA000_0001 + 32'(i), 4'hF, 1'b0, 5'(i + 1));
         tick();
         check("cmpl_vld", 32'(complete_vld_o), 1);
         check("cmpl_tag", 32'(complete_o), 32'(i + 1));
      end
      enq_valid_i = 0;
      check("cnt3", 32'(count_o), 3);
      check("nonspec_empty", 32'(no_nonspec_o), 1);
      check("no_drain_spec", 32'(store_valid_o), 0);
      tick();
      check("cmpl_drop", 32'(complete_vld_o), 0);

      // Commit two, drain back to back
      commit_cnt_i = 2;
      tick();
      commit_cnt_i = 0;
      check("nonspec_after_cmt", 32'(no_nonspec_o), 0);
      cache_done_i = 1;
      tick();
      check("drain0_vld", 32'(store_valid_o), 1);
      check("drain0_addr", 32'(store_address_o), 32'h10);
      check("drain0_data", 32'(store_data_o), 32'hA000_0001);
      tick();
      check("drain1_vld", 32'(store_valid_o), 1);
      check("drain1_addr", 32'(store_address_o), 32'h11);
      tick();
      check("drain_end_vld", 32'(store_valid_o), 0);
      check("drain_end_cnt", 32'(count_o), 1);
      check("drain_end_nonspec", 32'(no_nonspec_o), 1);
      cache_done_i = 0;

      // Partial-byte merge from two stores to one word
      enq_set(30'h20, 32'h0000_AAAA, 4'b0011, 1'b0, 5'd4);
      tick();
      enq_set(30'h20, 32'h00BB_BB00, 4'b0110, 1'b0, 5'd5);
      tick();
      enq_valid_i = 0;
      fwd_probe(30'h20, 4'b0111);
      check("fwd_merge_data", fwd_data_o, 32'h00BB_BBAA);
      check("fwd_merge_bm", 32'(fwd_bm_o), 32'h7);
      check("fwd_merge_res", 32'(fwd_resolvable_o), 1);
      fwd_probe(30'h20, 4'b1111);
      check("fwd_part_data", fwd_data_o, 32'h00BB_BBAA);
      check("fwd_part_hit", 32'(fwd_hit_o), 1);
      check("fwd_part_res", 32'(fwd_resolvable_o), 0);

      // IO store never resolves a load
      enq_set(30'h30, 32'h1234_5678, 4'hF, 1'b1, 5'd6);
      tick();
      enq_valid_i = 0;
      fwd_probe(30'h30, 4'b0011);
      check("fwd_io_data", fwd_data_o, 32'h0000_5678);
      check("fwd_io_hit", 32'(fwd_hit_o), 1);
      check("fwd_io_res", 32'(fwd_resolvable_o), 0);
      fwd_probe(30'h31, 4'hF);
      check("fwd_miss_hit", 32'(fwd_hit_o), 0);
      check("fwd_miss_data", fwd_data_o, 0);

      // Flush with an enqueue attempt: everything speculative goes, enqueue dropped
      flush_i = 1;
      enq_set(30'h40, 32'h0, 4'hF, 1'b0, 5'd7);
      tick();
      flush_i = 0; enq_valid_i = 0;
      check("flush_cmpl_vld", 32'(complete_vld_o), 0);
      check("flush_cnt", 32'(count_o), 0);
      fwd_probe(30'h20, 4'hF);
      check("flush_fwd_hit", 32'(fwd_hit_o), 0);

      // Fill all entries starting mid-array (head = 2)
      for (int i = 0; i < 16; i++) begin
         enq_set(30'h100 + 30'(i), 32'hC000_0000 + 32'(i), 4'hF, 1'b0, 5'(i));
         tick();
         check("fill_cmpl", 32'(complete_o), 32'(i));
      end
      enq_valid_i = 0;
      check("full_ready", 32'(enq_ready_o), 0);
      check("full_cnt", 32'(count_o), 16);
      enq_set(30'h1FF, 32'h0, 4'hF, 1'b0, 5'd31);
      tick();
      enq_valid_i = 0;
      check("full_drop_vld", 32'(complete_vld_o), 0);
      check("full_drop_cnt", 32'(count_o), 16);

      commit_cnt_i = 2;
      tick(); tick();
      commit_cnt_i = 0;
      check("cmt4_cnt", 32'(count_o), 16);
      check("cmt4_store_vld", 32'(store_valid_o), 1);
      check("cmt4_store_addr", 32'(store_address_o), 32'h100);
      flush_i = 1;
      tick();
      flush_i = 0;
      check("flush4_cnt", 32'(count_o), 4);
      check("flush4_store_vld", 32'(store_valid_o), 1);
      check("flush4_store_addr", 32'(store_address_o), 32'h100);
      check("flush4_ready", 32'(enq_ready_o), 1);
      fwd_probe(30'h100, 4'hF);
      check("fwd_inflight", fwd_data_o, 32'hC000_0000);
      fwd_probe(30'h103, 4'hF);
      check("fwd_committed", fwd_data_o, 32'hC000_0003);
      fwd_probe(30'h104, 4'hF);
      check("fwd_flushed_hit", 32'(fwd_hit_o), 0);

      // Refill across the wrap; entries 15 and 0 share one word
      for (int k = 0; k < 12; k++) begin
         if (k == 9)       enq_set(30'h300, 32'h1111_1111, 4'hF, 1'b0, 5'(16 + k));
         else if (k == 10) enq_set(30'h300, 32'h0000_00EE, 4'h1, 1'b0, 5'(16 + k));
         else              enq_set(30'h200 + 30'(k), 32'hE000_0000 + 32'(k), 4'hF, 1'b0, 5'(16 + k));
         tick();
         check("refill_cmpl", 32'(complete_o), 32'(16 + k));
      end
      enq_valid_i = 0;
      check("refill_cnt", 32'(count_o), 16);
      fwd_probe(30'h300, 4'hF);
      check("wrap_fwd_data", fwd_data_o, 32'h1111_11EE);
      check("wrap_fwd_bm", 32'(fwd_bm_o), 32'hF);
      check("wrap_fwd_res", 32'(fwd_resolvable_o), 1);

      // Drain while full: enqueue still refused this cycle
      cache_done_i = 1;
      enq_set(30'h400, 32'h0, 4'hF, 1'b0, 5'd30);
      #1;
      check("full_drain_ready", 32'(enq_ready_o), 0);
      tick();
      enq_valid_i = 0;
      check("full_drain_cmpl", 32'(complete_vld_o), 0);
      check("drainA_addr", 32'(store_address_o), 32'h101);
      check("drainA_cnt", 32'(count_o), 15);
      tick(); tick();
      check("drainC_addr", 32'(store_address_o), 32'h103);
      tick();
      cache_done_i = 0;
      check("drainD_vld", 32'(store_valid_o), 0);
      check("drainD_cnt", 32'(count_o), 12);

      // Async reset while a store is in flight
      commit_cnt_i = 2;
      tick();
      commit_cnt_i = 0;
      tick();
      check("pre_rst_vld", 32'(store_valid_o), 1);
      check("pre_rst_addr", 32'(store_address_o), 32'h200);
      #2;
      cpu_rst_i = 1;
      #1;
      check("async_rst_vld", 32'(store_valid_o), 0);
      check("async_rst_cnt", 32'(count_o), 0);
      @(posedge cpu_clk_i); #1;
      cpu_rst_i = 0;
      #1;
      check("post_rst_cnt", 32'(count_o), 0);
      check("post_rst_ready", 32'(enq_ready_o), 1);

      // Over-commit is clipped; flush keeps the committed entry
      enq_set(30'h500, 32'h5555_5555, 4'hF, 1'b0, 5'd9);
      tick();
      enq_valid_i = 0;
      commit_cnt_i = 2;
      tick();
      commit_cnt_i = 0;
      check("overcmt_cnt", 32'(count_o), 1);
      check("overcmt_nonspec", 32'(no_nonspec_o), 0);
      flush_i = 1;
      tick();
      flush_i = 0;
      check("flush_keep_cnt", 32'(count_o), 1);
      check("flush_keep_vld", 32'(store_valid_o), 1);
      check("flush_keep_addr", 32'(store_address_o), 32'h500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/store_queue_circ.md
Name: store_queue_circ

Overview:
- Parametrised successor to the shift-register store buffer: a circular store queue with configurable depth, ROB tag width and commit width.
- Holds speculative and committed stores, retires committed stores to the data cache one at a time, and forwards store data to loads per byte from the youngest matching entry.
- Flush discards only speculative entries, not committed ones.
- Sits between the AGU/store pipe, the ROB commit logic and the L1D write port.

Parameters:
- PHYS, 32, physical address width; word address is PHYS-2 bits.
- DEPTH, 16, number of queue entries; 2 to 64, any value (not restricted to powers of two).
- ROB_W, 5, ROB tag width.
- COMMIT_W, 2, maximum stores committed per cycle.

Ports:
- cpu_clk_i  in  1  clock.
- cpu_rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  pipeline flush; discards speculative entries.
- enq_valid_i  in  1  store enqueue request.
- enq_ready_o  out  1  queue can accept a store.
- enq_address_i  in  PHYS-2  word address.
- enq_data_i  in  32  store data.
- enq_bm_i  in  4  byte mask.
- enq_io_i  in  1  uncached/IO store.
- enq_rob_i  in  ROB_W  ROB tag.
- complete_o  out  ROB_W  ROB tag of the accepted store.
- complete_vld_o  out  1  completion pulse.
- commit_cnt_i  in  $clog2(COMMIT_W+1)  number of oldest speculative stores made non-speculative this cycle.
- fwd_address_i  in  PHYS-2  load word address.
- fwd_bm_i  in  4  load byte mask.
- fwd_data_o  out  32  forwarded bytes, merged.
- fwd_bm_o  out  4  load bytes covered by the queue.
- fwd_hit_o  out  1  any covered byte.
- fwd_resolvable_o  out  1  load fully satisfiable from the queue.
- store_address_o  out  PHYS-2  cache write address.
- store_data_o  out  32  cache write data.
- store_bm_o  out  4  cache write byte mask.
- store_io_o  out  1  cache write is IO.
- store_valid_o  out  1  cache write request.
- cache_done_i  in  1  cache accepted the write.
- no_nonspec_o  out  1  no committed-but-undrained entries.
- count_o  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- State: pointers head (oldest), cmt (first speculative entry) and tail (next free), each 0..DEPTH-1 and wrapping DEPTH-1 -> 0.
- Counters: ncount (non-speculative entries) and scount (speculative entries); count_o = ncount + scount.
- Reset (async): all pointers and counters = 0. Outputs at reset: store_valid_o=0, complete_vld_o=0, complete_o=0, store_* data fields=0. Combinationally this gives enq_ready_o=1 and no_nonspec_o=1. Entry payload RAM is not reset.
- Enqueue:
  - enq_ready_o = (count_o != DEPTH), combinational; it does not depend on same-cycle drain or flush.
  - Accept when enq_valid_i & enq_ready_o & !flush_i. An accepted store is written at tail and marked speculative; tail advances by 1.
  - An enqueue attempted in a flush cycle is dropped and gets no completion.
  - complete_vld_o/complete_o are registered: they pulse one cycle after acceptance with the accepted tag. complete_vld_o is forced to 0 in the cycle after a flush.
- Commit:
  - n = min(commit_cnt_i, scount). cmt advances by n, ncount += n, scount -= n.
  - commit_cnt_i > scount is a protocol error; the excess is ignored.
- Flush: first apply same-cycle commits, then tail <= new cmt and scount <= 0. Non-speculative entries and any in-flight store are untouched.
- Drain:
  - store_* outputs are registered.
  - When store_valid_o=0 and ncount>0, load the entry at head and set store_valid_o=1 next cycle.
  - Hold all store_* stable until cache_done_i. On cache_done_i: head advances and ncount decrements.
  - In the same edge, if ncount-1 > 0, load the entry at head+1 (zero-bubble back-to-back); otherwise store_valid_o <= 0.
  - cache_done_i while store_valid_o=0 is ignored.
- Forwarding (combinational):
  - Candidates are all live entries from head up to tail, including the entry currently being drained.
  - An entry matches byte b if its address equals fwd_address_i, its bm[b]=1 and fwd_bm_i[b]=1.
  - For each byte, select the youngest matching entry (nearest tail) and place its byte in fwd_data_o.
  - Uncovered bytes read 0.
  - fwd_bm_o = OR of all matching bytes; fwd_hit_o = |fwd_bm_o.
  - fwd_resolvable_o = fwd_hit_o & (fwd_bm_o == fwd_bm_i) & no contributing entry has io set.
- no_nonspec_o = (ncount == 0), combinational.
- Simultaneous events: enqueue, commit, drain-done and flush in one cycle are all legal. Counter updates compose in this order: drain, commit, flush, enqueue. Full plus drain done in the same cycle still has enq_ready_o=0 that cycle.
- Pointer wrap: every pointer increment is modulo DEPTH. Forwarding age ordering is correct across the wrap.

Test Plan:
- Reset then enqueue 3 stores (addr 0x10/0x11/0x12, tags 1,2,3) -> complete pulses 1,2,3 on consecutive cycles; count_o=3; no_nonspec_o=1; store_valid_o stays 0.
- commit_cnt_i=2 then cache_done_i held high -> store to 0x10 then 0x11 presented on back-to-back cycles; then store_valid_o=0; count_o=1.
- Stores to 0x20: bm=0011 data 0x0000AAAA, then bm=0110 data 0x00BBBB00; load fwd bm=0111 -> fwd_data_o=0x00BBBBAA, fwd_bm_o=0111, resolvable=1. Same with load bm=1111 -> resolvable=0, hit=1.
- DEPTH=16: fill all 16 -> enq_ready_o=0; commit 4; flush -> count_o=4, tail=cmt. Further enqueues resume at index 4 and wrap correctly after 16 total accepts.
- Matching IO store covering the load bytes -> fwd_hit_o=1, fwd_resolvable_o=0.
- Assert cpu_rst_i while store_valid_o=1 -> store_valid_o=0 immediately; count_o=0 after release.
